block_fir_mul_pipe: RTL and testbench

BLOCK_FIR_MUL_PIPE -- requirements
Module: block_fir_mul_pipe

---
 rtl/block_fir_mul_pkg.sv | 10 +
 rtl/block_fir_mul_sat.sv | 43 ++++
 rtl/block_fir_mul_pipe.sv | 105 ++++++++++
 tb/tb_block_fir_mul_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_fir_mul_pkg.sv
// rtl/block_fir_mul_pkg.sv - shared constants for the pipelined signed multiplier
package block_fir_mul_pkg;

    localparam int MUL_WRAP = 0;
    localparam int MUL_SAT  = 1;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 6;

endpackage

// File: rtl/block_fir_mul_sat.sv
// rtl/block_fir_mul_sat.sv - shift, wrap/saturate and overflow flag for a full-width product
module block_fir_mul_sat
    import block_fir_mul_pkg::*;
#(
    parameter int PW         = 64,
    parameter int DOUT_WIDTH = 32,
    parameter int SHIFT      = 0,
    parameter int SAT_MODE   = MUL_WRAP
) (
    input  logic signed [PW-1:0]         p,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int RW = PW - SHIFT;

    logic signed [PW-1:0] r;

    assign r = p >>> SHIFT;

    if (DOUT_WIDTH >= RW) begin : g_fits
        // Shifted product always fits: sign-extend (or drop pure sign-copy bits)
        assign dout = DOUT_WIDTH'(r);
        assign ovf  = 1'b0;
    end else begin : g_narrow
        localparam logic [DOUT_WIDTH-1:0] DMIN = DOUT_WIDTH'(1) << (DOUT_WIDTH - 1);

        logic [PW-DOUT_WIDTH:0] hi;
        logic                   fits;

        // Representable exactly when every bit from the result sign upward agrees
        assign hi   = r[PW-1:DOUT_WIDTH-1];
        assign fits = (&hi) | (~|hi);
        assign ovf  = ~fits;

        if (SAT_MODE == MUL_SAT) begin : g_sat
            assign dout = fits ? r[DOUT_WIDTH-1:0] : (r[PW-1] ? DMIN : ~DMIN);
        end else begin : g_wrap
            assign dout = r[DOUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/block_fir_mul_pipe.sv
// rtl/block_fir_mul_pipe.sv - elastic NUM_STAGE-deep signed multiplier with wrap/saturate output
module block_fir_mul_pipe
    import block_fir_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int DOUT_WIDTH = 32,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0,
    parameter int SAT_MODE   = MUL_WRAP
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("block_fir_mul_pipe: NUM_STAGE out of range");
    end
    if (SHIFT < 0 || SHIFT > PW - 1) begin : g_bad_shift
        $error("block_fir_mul_pipe: SHIFT out of range");
    end
    if (SAT_MODE != MUL_WRAP && SAT_MODE != MUL_SAT) begin : g_bad_sat
        $error("block_fir_mul_pipe: SAT_MODE must be MUL_WRAP or MUL_SAT");
    end
    if (DIN0_WIDTH < 1 || DIN1_WIDTH < 1 || DOUT_WIDTH < 1) begin : g_bad_width
        $error("block_fir_mul_pipe: widths must be positive");
    end

    logic [NUM_STAGE-1:0] vld;
    logic [NUM_STAGE:0]   rdy;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] pd [NUM_STAGE];

    assign prod = PW'(din0) * PW'(din1);

    // A stage may load when it is empty or everything downstream will move
    always_comb begin
        rdy[NUM_STAGE] = out_ready;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            rdy[k] = ~vld[k] | rdy[k+1];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                pd[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    pd[0] <= prod;
                end
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        pd[k] <= pd[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[NUM_STAGE-1];

    // Final-stage product register is cleared on reset, so dout/ovf read 0
    block_fir_mul_sat #(
        .PW         (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .SAT_MODE   (SAT_MODE)
    ) u_sat (
        .p    (pd[NUM_STAGE-1]),
        .dout (dout),
        .ovf  (ovf)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_fir_mul_pipe.sv
// tb/tb_block_fir_mul_pipe.sv - randomized scoreboard bench over four multiplier configurations
module tb_block_fir_mul_pipe;

    typedef logic signed [63:0] val_t;
    typedef struct {
        int a;
        int b;
        int cyc;
    } item_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              out_ready;
    logic              ovf_clr;
    logic signed [7:0] din0;
    logic signed [7:0] din1;

    logic               ir_a, ov_a, f_a, st_a;
    logic signed [7:0]  d_a;
    logic               ir_s, ov_s, f_s, st_s;
    logic signed [7:0]  d_s;
    logic               ir_w, ov_w, f_w, st_w;
    logic signed [15:0] d_w;
    logic               ir_h, ov_h, f_h, st_h;
    logic signed [7:0]  d_h;

    always #5 clk = ~clk;

    block_fir_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3), .SHIFT(0), .SAT_MODE(0)) u_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .din0(din0), .din1(din1),
        .out_valid(ov_a), .out_ready(out_ready), .dout(d_a), .ovf(f_a), .ovf_sticky(st_a), .ovf_clr(ovf_clr));
    block_fir_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3), .SHIFT(0), .SAT_MODE(1)) u_s (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s), .din0(din0), .din1(din1),
        .out_valid(ov_s), .out_ready(out_ready), .dout(d_s), .ovf(f_s), .ovf_sticky(st_s), .ovf_clr(ovf_clr));
    block_fir_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(3), .SHIFT(0), .SAT_MODE(0)) u_w (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w), .din0(din0), .din1(din1),
        .out_valid(ov_w), .out_ready(out_ready), .dout(d_w), .ovf(f_w), .ovf_sticky(st_w), .ovf_clr(ovf_clr));
    block_fir_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3), .SHIFT(4), .SAT_MODE(1)) u_h (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_h), .din0(din0), .din1(din1),
        .out_valid(ov_h), .out_ready(out_ready), .dout(d_h), .ovf(f_h), .ovf_sticky(st_h), .ovf_clr(ovf_clr));

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    item_t q[$];
    bit    lat_chk;
    bit    exp_sticky;
    bit    stalled_prev;
    bit    popped;
    val_t  held_d [4];
    val_t  last_d [4];
    val_t  last_o [4];

    int cfg_sh  [4] = '{0, 0, 0, 4};
    int cfg_dw  [4] = '{8, 8, 16, 8};
    bit cfg_sat [4] = '{0, 1, 0, 1};

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic val_t obs_d(input int i);
        case (i)
            0:       return val_t'(d_a);
            1:       return val_t'(d_s);
            2:       return val_t'(d_w);
            default: return val_t'(d_h);
        endcase
    endfunction

    function automatic val_t obs_f(input int i);
        case (i)
            0:       return val_t'({1'b0, f_a});
            1:       return val_t'({1'b0, f_s});
            2:       return val_t'({1'b0, f_w});
            default: return val_t'({1'b0, f_h});
        endcase
    endfunction

    function automatic val_t obs_v(input int i);
        case (i)
            0:       return val_t'({1'b0, ov_a});
            1:       return val_t'({1'b0, ov_s});
            2:       return val_t'({1'b0, ov_w});
            default: return val_t'({1'b0, ov_h});
        endcase
    endfunction

    function automatic val_t obs_r(input int i);
        case (i)
            0:       return val_t'({1'b0, ir_a});
            1:       return val_t'({1'b0, ir_s});
            2:       return val_t'({1'b0, ir_w});
            default: return val_t'({1'b0, ir_h});
        endcase
    endfunction

    // Exact product, floor shift, then wrap or clamp into a dw-bit signed range
    function automatic void model(input int a, input int b, input int sh, input int dw, input bit sat,
                                  output val_t d, output bit o);
        longint r, span, lo, hi;
        r    = (longint'(a) * longint'(b)) >>> sh;
        span = longint'(1) <<< dw;
        lo   = -(span / 2);
        hi   = span / 2 - 1;
        if (r < lo || r > hi) begin
            o = 1'b1;
            if (sat) begin
                d = (r < lo) ? lo : hi;
            end else begin
                d = r & (span - 1);
                if (d > hi) d = d - span;
            end
        end else begin
            o = 1'b0;
            d = r;
        end
    endfunction

    function automatic int rnd8();
        case ($urandom_range(0, 7))
            0:       return -128;
            1:       return 127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    // One clock: entered and left at a falling edge
    task automatic cycle(input bit iv, input int a, input int b, input bit ordy, input bit clr);
        item_t e;
        val_t  d;
        bit    o;
        bit    set;
        in_valid  = iv;
        din0      = 8'(a);
        din1      = 8'(b);
        out_ready = ordy;
        ovf_clr   = clr;
        #1;
        if (stalled_prev) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("stall_valid%0d", i), obs_v(i), 1);
                check($sformatf("stall_dout%0d", i), obs_d(i), held_d[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("in_ready%0d", i), obs_r(i), val_t'((q.size() < 3) || ordy));
        end
        popped = 1'b0;
        set    = 1'b0;
        if (ov_a && ordy) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                popped = 1'b1;
                if (lat_chk) check("latency", cyc - e.cyc, 3);
                for (int i = 0; i < 4; i++) begin
                    model(e.a, e.b, cfg_sh[i], cfg_dw[i], cfg_sat[i], d, o);
                    if (i > 0) check($sformatf("out_valid%0d", i), obs_v(i), 1);
                    check($sformatf("dout%0d", i), obs_d(i), d);
                    check($sformatf("ovf%0d", i), obs_f(i), val_t'(o));
                    last_d[i] = obs_d(i);
                    last_o[i] = obs_f(i);
                    if (i == 0) set = o;
                end
            end
        end
        if (iv && ir_a) q.push_back('{a: a, b: b, cyc: cyc});
        stalled_prev = ov_a && !ordy;
        for (int i = 0; i < 4; i++) held_d[i] = obs_d(i);
        exp_sticky = set ? 1'b1 : (clr ? 1'b0 : exp_sticky);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("ovf_sticky", val_t'({1'b0, st_a}), val_t'(exp_sticky));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        check("drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; din0 = '0; din1 = '0;
        exp_sticky = 1'b0; stalled_prev = 1'b0; lat_chk = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", val_t'({1'b0, ov_a}), 0);
        check("rst_dout", val_t'(d_a), 0);
        check("rst_dout_w", val_t'(d_w), 0);
        check("rst_ovf", val_t'({1'b0, f_a}), 0);
        check("rst_sticky", val_t'({1'b0, st_a}), 0);
        check("rst_in_ready", val_t'({1'b0, ir_a}), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Most-negative squared: wraps to 0 or clamps to 127; clear collides with the set
        cycle(1'b1, -128, -128, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        check("sq_popped", val_t'({1'b0, popped}), 1);
        check("sq_wrap_dout", last_d[0], 0);
        check("sq_wrap_ovf", last_o[0], 1);
        check("sq_sat_dout", last_d[1], 127);
        check("sq_sat_ovf", last_o[1], 1);
        check("sticky_set_wins", val_t'({1'b0, st_a}), 1);
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        check("sticky_cleared", val_t'({1'b0, st_a}), 0);

        // Wide output holds the exact product; shifted 8-bit output saturates low
        cycle(1'b1, -128, 127, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        check("wide_dout", last_d[2], -16256);
        check("wide_ovf", last_o[2], 0);
        check("shift_sat_dout", last_d[3], -128);
        check("shift_sat_ovf", last_o[3], 1);

        // Back-to-back stream, consumer always ready
        for (int i = 0; i < 100; i++) cycle(1'b1, rnd8(), rnd8(), 1'b1, 1'b0);
        drain();

        // Random producer and consumer
        lat_chk = 1'b0;
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), rnd8(), rnd8(), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        drain();

        // Reset with results in flight, one of them presented at the output
        cycle(1'b1, 5, 7, 1'b0, 1'b0);
        cycle(1'b1, -3, 9, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        check("pre_rst_valid", val_t'({1'b0, ov_a}), 1);
        check("pre_rst_dout", val_t'(d_a), 35);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", val_t'({1'b0, ov_a}), 0);
        check("mid_rst_dout", val_t'(d_a), 0);
        check("mid_rst_dout_w", val_t'(d_w), 0);
        check("mid_rst_sticky", val_t'({1'b0, st_a}), 0);
        q.delete();
        exp_sticky   = 1'b0;
        stalled_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", val_t'({1'b0, ir_a}), 1);
        repeat (6) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        check("post_rst_no_stale", val_t'({1'b0, ov_a}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
